// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared screen geometry, colours, engine state encoding and
//                the paddle move rule.
//  Revision    : 1.0
// ============================================================================
package game_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam logic [2:0] COL_BG = 3'b000;
   localparam logic [2:0] COL_FG = 3'b111;

   typedef enum logic [2:0] {
      ST_WAIT  = 3'd0,
      ST_ERASE = 3'd1,
      ST_MOVE  = 3'd2,
      ST_DRAW  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Nine-bit arithmetic keeps pos+step from wrapping before the clamp.
   function automatic logic [7:0] next_pos(input logic [7:0] pos,
                                           input logic       l,
                                           input logic       r,
                                           input int         step,
                                           input int         lo,
                                           input int         hi);
      logic [8:0] p9;
      logic [8:0] s9;
      p9       = {1'b0, pos};
      s9       = p9 + 9'(step);
      next_pos = pos;
      if (r && !l) begin
         next_pos = (s9 > 9'(hi)) ? 8'(hi) : s9[7:0];
      end else if (l && !r) begin
         next_pos = (p9 < 9'(lo + step)) ? 8'(lo) : 8'(p9 - 9'(step));
      end
   endfunction

endpackage
`default_nettype wire

// File: rtl/frame_timer.sv
`default_nettype none
// ============================================================================
//  Module      : frame_timer
//  Description : Free-running divider, one-cycle tick every FRAME_TICKS clks.
//  Revision    : 1.0
// ============================================================================
module frame_timer #(
   parameter int FRAME_TICKS = 833334
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int CW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(FRAME_TICKS - 1);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (r_count == C_LAST) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CW'(1);
      end
   end

   assign tick = (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/paddle_engine.sv
`default_nettype none
// ============================================================================
//  Module      : paddle_engine
//  Description : Per-frame erase / move / redraw of horizontal paddles
//                streamed as single pixels to a 160x120 VGA adapter.
//  Revision    : 1.0
// ============================================================================
module paddle_engine
   import game_pkg::*;
#(
   parameter int NUM_PADDLES = 2,
   parameter int PAD_W       = 16,
   parameter int STEP        = 1,
   parameter int FRAME_TICKS = 833334,
   parameter int X_MIN       = 2,
   parameter int X_MAX       = 157,
   parameter logic [7*NUM_PADDLES-1:0] Y_ROWS = {7'd8, 7'd110}
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [NUM_PADDLES-1:0]   left,
   input  logic [NUM_PADDLES-1:0]   right,
   output logic [7:0]               x_out,
   output logic [6:0]               y_out,
   output logic [2:0]               colour,
   output logic                     plot,
   output logic                     frame_done,
   output logic                     busy,
   output logic [8*NUM_PADDLES-1:0] pos_x
);

   localparam int IW = $clog2(NUM_PADDLES + 1);
   localparam int KW = $clog2(PAD_W);
   localparam logic [7:0]    C_CENTRE = 8'((X_MIN + X_MAX - PAD_W) / 2);
   localparam logic [KW-1:0] C_K_LAST = KW'(PAD_W - 1);

   state_t                   r_state;
   state_t                   w_next;
   logic                     w_tick;
   logic [8*NUM_PADDLES-1:0] r_pos;
   logic [8*NUM_PADDLES-1:0] r_target;
   logic [8*NUM_PADDLES-1:0] w_target;
   logic [NUM_PADDLES-1:0]   r_dirty;
   logic [NUM_PADDLES-1:0]   w_dirty;
   logic                     r_force;
   logic [IW-1:0]            r_pidx;
   logic [IW-1:0]            w_cur;
   logic                     w_found;
   logic [KW-1:0]            r_k;
   logic [7:0]               w_px;
   logic [6:0]               w_py;
   logic                     r_plot;
   logic [7:0]               r_x;
   logic [6:0]               r_y;
   logic [2:0]               r_col;

   frame_timer #(
      .FRAME_TICKS (FRAME_TICKS)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .tick  (w_tick)
   );

   // Movement is resolved as the frame starts so ERASE knows which paddles
   // are about to change; the stored target is committed in MOVE.
   generate
      for (genvar i = 0; i < NUM_PADDLES; i++) begin : g_pad
         assign w_target[8*i +: 8] = next_pos(r_pos[8*i +: 8], left[i], right[i],
                                              STEP, X_MIN, X_MAX - PAD_W);
         assign w_dirty[i] = r_force || (w_target[8*i +: 8] != r_pos[8*i +: 8]);
      end
   endgenerate

   // Lowest dirty paddle at or above the cursor; clean paddles cost no cycles.
   always_comb begin
      w_found = 1'b0;
      w_cur   = '0;
      w_px    = '0;
      w_py    = '0;
      for (int i = NUM_PADDLES - 1; i >= 0; i--) begin
         if ((IW'(i) >= r_pidx) && r_dirty[i]) begin
            w_found = 1'b1;
            w_cur   = IW'(i);
            w_px    = r_pos[8*i +: 8];
            w_py    = Y_ROWS[7*i +: 7];
         end
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_WAIT:  if (w_tick && enable) w_next = ST_ERASE;
         ST_ERASE: if (!w_found)         w_next = ST_MOVE;
         ST_MOVE:                        w_next = ST_DRAW;
         ST_DRAW:  if (!w_found)         w_next = ST_DONE;
         ST_DONE:                        w_next = ST_WAIT;
         default:                        w_next = ST_WAIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_WAIT;
         r_pos    <= {NUM_PADDLES{C_CENTRE}};
         r_target <= {NUM_PADDLES{C_CENTRE}};
         r_dirty  <= '1;
         r_force  <= 1'b1;
         r_pidx   <= '0;
         r_k      <= '0;
         r_plot   <= 1'b0;
         r_x      <= '0;
         r_y      <= '0;
         r_col    <= COL_BG;
      end else begin
         r_state <= w_next;
         r_plot  <= 1'b0;
         r_x     <= '0;
         r_y     <= '0;
         r_col   <= COL_BG;
         case (r_state)
            ST_WAIT: begin
               if (w_tick && enable) begin
                  r_target <= w_target;
                  r_dirty  <= w_dirty;
                  r_pidx   <= '0;
                  r_k      <= '0;
               end
            end
            ST_ERASE, ST_DRAW: begin
               if (w_found) begin
                  r_plot <= 1'b1;
                  r_x    <= w_px + 8'(r_k);
                  r_y    <= w_py;
                  r_col  <= (r_state == ST_DRAW) ? COL_FG : COL_BG;
                  if (r_k == C_K_LAST) begin
                     r_k    <= '0;
                     r_pidx <= w_cur + IW'(1);
                  end else begin
                     r_k <= r_k + KW'(1);
                  end
               end else begin
                  r_k    <= '0;
                  r_pidx <= '0;
               end
            end
            ST_MOVE: r_pos   <= r_target;
            ST_DONE: r_force <= 1'b0;
            default: ;
         endcase
      end
   end

   assign plot       = r_plot;
   assign x_out      = r_x;
   assign y_out      = r_y;
   assign colour     = r_col;
   assign pos_x      = r_pos;
   assign frame_done = (r_state == ST_DONE);
   assign busy       = (r_state == ST_ERASE) || (r_state == ST_MOVE) || (r_state == ST_DRAW);

endmodule
`default_nettype wire
